rat_path_collector: RTL
=======================

Name: rat_path_collector

Overview:
- Receiving end of the maze-solver move stream.
- The solver controller replays its final path one move per cycle while it drains its second stack: the move buffer enable is high and the 2-bit direction is on Creg.
- This block captures those moves into an internal buffer and tracks the rat's position from (0,0) to check that the path stays in bounds and ends at the goal cell.
- A host then reads the validated path back one move at a time.

Parameters:
- N, 16, maze side length; coordinates are 0..N-1.
- DEPTH, 64, move buffer capacity (entries of 2 bits).
- CW, 4, coordinate width, equal to $clog2(N).
- PW, 7, pointer/length width, equal to $clog2(DEPTH)+1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start_rx  in  1  clear the block and begin collecting; accepted in any state.
- mv_valid  in  1  one move present this cycle (driven by the solver's enMBuff).
- mv_dir  in  2  move direction (driven from Creg).
- mv_last  in  1  end of path; may coincide with mv_valid.
- rd_en  in  1  host read request.
- rd_valid  out  1  rd_dir valid this cycle.
- rd_dir  out  2  move read back.
- rd_empty  out  1  all stored moves have been read.
- path_len  out  PW  number of moves captured.
- cur_x  out  CW  tracked X position.
- cur_y  out  CW  tracked Y position.
- busy  out  1  high in COLLECT and CHECK.
- ready  out  1  path validated; readout allowed.
- err  out  1  path rejected.
- err_code  out  2  reason for rejection.

Behaviour:
- Reset (rst low, asynchronous): state IDLE. All outputs 0, pointers 0, cur_x/cur_y 0, err_code NONE.
- Direction decode is packaged:
  - 00 gives X+1.
  - 11 gives X-1.
  - 01 gives Y+1.
  - 10 gives Y-1.
  - Directions with equal bits move X; differing bits move Y, consistent with the solver's ldX/ldY split.
- States: IDLE, COLLECT, CHECK, READY, ERROR.
- start_rx from any state: next cycle enters COLLECT with pointers, length and position cleared and err cleared. It overrides every other input that cycle.
- COLLECT, mv_valid=1:
  - If wr_ptr==DEPTH: go to ERROR with code OVERFLOW. Nothing is written.
  - Else if the move takes cur_x or cur_y below 0 or above N-1: go to ERROR with code OOB. Position is unchanged and nothing is written.
  - Else: write mv_dir at wr_ptr, increment wr_ptr and path_len, update the position. All updates are registered and visible the next cycle.
- mv_last=1 in COLLECT: after processing any same-cycle move, go to CHECK. With mv_last and no mv_valid, only the transition occurs.
- mv_valid outside COLLECT is ignored.
- CHECK (exactly 1 cycle):
  - (cur_x,cur_y)==(N-1,N-1) and path_len>0: go to READY.
  - Otherwise: go to ERROR with code NOT_GOAL.
- READY:
  - rd_en with rd_ptr<wr_ptr: the next cycle has rd_valid=1 and rd_dir=buf[rd_ptr], then rd_ptr increments. Latency is 1 cycle and one move is read per cycle back-to-back.
  - rd_en with rd_ptr==wr_ptr: ignored, rd_valid=0.
  - rd_empty = (rd_ptr==wr_ptr) in READY, else 0.
- ERROR: sticky until start_rx or reset. ready=0.
- err_code values: 00 NONE, 01 OOB, 10 OVERFLOW, 11 NOT_GOAL. The first error wins.
- Reset mid-operation: immediate return to IDLE. Buffer contents are don't-care.

Optional Feature:
- Macro: RAT_PATH_REPLAY_EN.
- Defined:
  - Extra input port replay (1 bit).
  - In READY, replay=1 sets rd_ptr=0 next cycle so the path can be re-read.
  - replay has priority over a same-cycle rd_en; that rd_en is dropped.
- Undefined: the port is absent and the path is readable exactly once.

Decomposition:
- Package rat_path_pkg holds:
  - the direction typedef (enum logic[1:0] DIR_XP, DIR_YP, DIR_YM, DIR_XM);
  - the err_code enum;
  - the state enum;
  - a function next_pos(x, y, dir) returning the new coordinates plus an out-of-bounds flag.
- One sub-module: rat_move_buf, a DEPTH x 2 register buffer with write/read pointers, count and an empty flag.
- The FSM and position tracker stay in the top module.

Test Plan:
- Good path, N=4:
  - Stimulus: start_rx, then moves XP,XP,XP,YP,YP,YP with mv_last on the 6th move.
  - Required: CHECK, then ready=1, path_len=6, cur=(3,3).
  - Then 6 rd_en cycles: rd_dir sequence 00,00,00,01,01,01, each one cycle after its rd_en, then rd_empty=1.
- Out of bounds: first move XM from (0,0) -> err=1, err_code=01, path_len=0. Later mv_valid is ignored.
- Overflow, DEPTH=4: 5 in-bounds moves -> err_code=10 on the 5th, path_len=4.
- Not at goal: moves XP,YP then mv_last alone -> err_code=11, cur=(1,1).
- Reset and restart:
  - rst low mid-COLLECT after 3 moves -> all outputs 0 immediately.
  - start_rx during ERROR -> COLLECT with err=0, len=0.
- With RAT_PATH_REPLAY_EN: after a full readout, replay=1 -> rd_empty=0 and the next rd_en returns the first move again.

Source files
------------

// File: rtl/rat_path_pkg.sv
// Shared types for the maze-path collector: move directions, error codes,
// FSM states and the position-step helper used by the tracker.
package rat_path_pkg;

    // Equal bits move X, differing bits move Y (matches solver ldX/ldY split)
    typedef enum logic [1:0] {
        DIR_XP = 2'b00,
        DIR_YP = 2'b01,
        DIR_YM = 2'b10,
        DIR_XM = 2'b11
    } dir_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_OOB      = 2'b01,
        ERR_OVERFLOW = 2'b10,
        ERR_NOT_GOAL = 2'b11
    } err_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_CHECK,
        S_READY,
        S_ERROR
    } state_e;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic        oob;
    } pos_t;

    // One step from (x,y) in direction d on an n x n grid
    function automatic pos_t next_pos(input int x, input int y,
                                      input dir_e d, input int n);
        pos_t p;
        int   nx;
        int   ny;
        nx = x;
        ny = y;
        unique case (d)
            DIR_XP: nx = x + 1;
            DIR_XM: nx = x - 1;
            DIR_YP: ny = y + 1;
            DIR_YM: ny = y - 1;
        endcase
        p.x   = nx;
        p.y   = ny;
        p.oob = (nx < 0) || (nx > n - 1) || (ny < 0) || (ny > n - 1);
        return p;
    endfunction

endpackage

// File: rtl/rat_path_collector_if.sv
// Move stream (solver -> collector) and host readback port.
// master: solver/host side; slave: the collector.
interface rat_path_collector_if;
    logic       mv_valid;
    logic [1:0] mv_dir;
    logic       mv_last;
    logic       rd_en;
    logic       rd_valid;
    logic [1:0] rd_dir;
    logic       rd_empty;

    modport master (
        output mv_valid, mv_dir, mv_last, rd_en,
        input  rd_valid, rd_dir, rd_empty
    );

    modport slave (
        input  mv_valid, mv_dir, mv_last, rd_en,
        output rd_valid, rd_dir, rd_empty
    );
endinterface

// File: rtl/rat_move_buf.sv
// DEPTH x 2-bit move store with write/read pointers.
// Ports: clr_i clears pointers, wr_*/rd_* step pointers, rewind_i resets rd.
module rat_move_buf #(
    parameter int DEPTH = 64,
    parameter int PW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          wr_en_i,
    input  logic [1:0]    wr_dir_i,
    input  logic          rd_en_i,
    input  logic          rewind_i,
    output logic [1:0]    rd_dir_o,
    output logic [PW-1:0] count_o,
    output logic          empty_o,
    output logic          full_o
);
    localparam int AW = PW - 1;

    logic [1:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_en_i)
                wr_ptr_d = wr_ptr_q + PW'(1);
            if (rewind_i)
                rd_ptr_d = '0;
            else if (rd_en_i)
                rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Contents are don't-care after reset, so no reset on the array
    always_ff @(posedge clk) begin
        if (wr_en_i && !clr_i)
            mem_q[wr_ptr_q[AW-1:0]] <= wr_dir_i;
    end

    assign rd_dir_o = mem_q[rd_ptr_q[AW-1:0]];
    assign count_o  = wr_ptr_q;
    assign empty_o  = (rd_ptr_q == wr_ptr_q);
    assign full_o   = (wr_ptr_q == PW'(DEPTH));

endmodule

// File: rtl/rat_path_collector.sv
// Captures the solver's replayed path, tracks position from (0,0), checks
// bounds/goal, then serves moves to a host. Optional: RAT_PATH_REPLAY_EN.
// Ports: clk, rst (async low), start_rx, [replay], io (move/read bus),
//        path_len, cur_x, cur_y, busy, ready, err, err_code.
module rat_path_collector
    import rat_path_pkg::*;
#(
    parameter int N     = 16,
    parameter int DEPTH = 64,
    parameter int CW    = $clog2(N),
    parameter int PW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_rx,
`ifdef RAT_PATH_REPLAY_EN
    input  logic          replay,
`endif
    rat_path_collector_if.slave io,
    output logic [PW-1:0] path_len,
    output logic [CW-1:0] cur_x,
    output logic [CW-1:0] cur_y,
    output logic          busy,
    output logic          ready,
    output logic          err,
    output logic [1:0]    err_code
);

    state_e        state_q;
    err_e          err_code_q;
    logic [CW-1:0] cur_x_q, cur_x_d;
    logic [CW-1:0] cur_y_q, cur_y_d;
    logic          rd_valid_q;
    logic [1:0]    rd_dir_q;

    pos_t          np;
    logic          oob;
    logic          replay_w;
    logic          in_collect;
    logic          in_ready;
    logic          wr_en;
    logic          rd_go;
    logic          rewind;
    logic [1:0]    buf_dir;
    logic [PW-1:0] count;
    logic          empty;
    logic          full;

`ifdef RAT_PATH_REPLAY_EN
    assign replay_w = replay;
`else
    assign replay_w = 1'b0;
`endif

    // Coordinates that do not fit the register are also out of range
    always_comb begin
        np      = next_pos(int'(cur_x_q), int'(cur_y_q),
                           dir_e'(io.mv_dir), N);
        oob     = np.oob || (|np.x[31:CW]) || (|np.y[31:CW]);
        cur_x_d = np.x[CW-1:0];
        cur_y_d = np.y[CW-1:0];
    end

    // start_rx overrides everything, so it gates all buffer activity
    assign in_collect = (state_q == S_COLLECT) && !start_rx;
    assign in_ready   = (state_q == S_READY) && !start_rx;
    assign wr_en      = in_collect && io.mv_valid && !full && !oob;
    assign rewind     = in_ready && replay_w;
    assign rd_go      = in_ready && io.rd_en && !empty && !replay_w;

    rat_move_buf #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst),
        .clr_i    (start_rx),
        .wr_en_i  (wr_en),
        .wr_dir_i (io.mv_dir),
        .rd_en_i  (rd_go),
        .rewind_i (rewind),
        .rd_dir_o (buf_dir),
        .count_o  (count),
        .empty_o  (empty),
        .full_o   (full)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            err_code_q <= ERR_NONE;
            cur_x_q    <= '0;
            cur_y_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_dir_q   <= '0;
        end else begin
            rd_valid_q <= rd_go;
            if (rd_go)
                rd_dir_q <= buf_dir;
            if (start_rx) begin
                state_q    <= S_COLLECT;
                err_code_q <= ERR_NONE;
                cur_x_q    <= '0;
                cur_y_q    <= '0;
            end else begin
                unique case (state_q)
                    S_COLLECT: begin
                        if (io.mv_valid && full) begin
                            state_q    <= S_ERROR;
                            err_code_q <= ERR_OVERFLOW;
                        end else if (io.mv_valid && oob) begin
                            state_q    <= S_ERROR;
                            err_code_q <= ERR_OOB;
                        end else begin
                            if (io.mv_valid) begin
                                cur_x_q <= cur_x_d;
                                cur_y_q <= cur_y_d;
                            end
                            if (io.mv_last)
                                state_q <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        if (cur_x_q == CW'(N - 1) &&
                            cur_y_q == CW'(N - 1) &&
                            count != '0) begin
                            state_q <= S_READY;
                        end else begin
                            state_q    <= S_ERROR;
                            err_code_q <= ERR_NOT_GOAL;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy        = (state_q == S_COLLECT) || (state_q == S_CHECK);
    assign ready       = (state_q == S_READY);
    assign err         = (state_q == S_ERROR);
    assign err_code    = err_code_q;
    assign path_len    = count;
    assign cur_x       = cur_x_q;
    assign cur_y       = cur_y_q;
    assign io.rd_valid = rd_valid_q;
    assign io.rd_dir   = rd_dir_q;
    assign io.rd_empty = (state_q == S_READY) && empty;

endmodule
